// File: rtl/isa_io_target.sv
// ISA peripheral-side target. Decodes a 16-port I/O window, turns IOW#/IOR# cycles into
// local-bus write events and read requests, accepts single-mode 8-bit DMA writes and
// drives one level-sensitive IRQ. All ISA inputs are synchronised to clk here.
module isa_io_target #(
  parameter logic [15:0] BASE_ADDR   = 16'h0220,
  parameter int unsigned RD_TIMEOUT  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] isa_address,
  input  logic        isa_aen,
  input  logic        isa_ior_n,
  input  logic        isa_iow_n,
  input  logic        isa_dack_n,
  input  logic        isa_reset,
  input  logic [7:0]  isa_data_in,
  output logic [7:0]  isa_data_out,
  output logic        isa_data_oe,
  output logic        isa_drq,
  output logic        isa_irq,
  output logic        wr_valid,
  output logic [3:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        rd_req,
  output logic [3:0]  rd_addr,
  input  logic        rd_valid,
  input  logic [7:0]  rd_data,
  input  logic        dma_ready,
  output logic        dma_valid,
  output logic [7:0]  dma_data,
  input  logic        irq_set,
  input  logic        irq_clr
);

  localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StIoWr,
    StRdWait,
    StRdDrive,
    StDmaWr
  } state_e;

  state_e state;

  // Synchroniser chains; bit/entry 0 is the first flop.
  logic [SYNC_STAGES-1:0] ior_sync;
  logic [SYNC_STAGES-1:0] iow_sync;
  logic [SYNC_STAGES-1:0] dack_sync;
  logic [SYNC_STAGES-1:0] aen_sync;
  logic [SYNC_STAGES-1:0] rst_sync;
  logic [15:0]            addr_sync [SYNC_STAGES];
  logic [7:0]             data_sync [SYNC_STAGES];

  logic        ior_s, iow_s, dack_s, aen_s, isa_reset_s;
  logic [15:0] addr_s;
  logic [7:0]  data_s;

  // Previous synced strobe levels for edge detection.
  logic ior_q, iow_q, dack_q;

  logic          ior_fall, iow_fall, ior_rise, iow_rise, dack_fall;
  logic          hit;
  logic          both_low;
  logic [7:0]    data_hold;
  logic [TW-1:0] rd_timer;
  logic          drq_block;
  logic          irq_latch;

  // Sync chains are not reset so they keep tracking the bus while reset is held.
  always_ff @(posedge clk) begin
    ior_sync  <= {ior_sync[SYNC_STAGES-2:0], isa_ior_n};
    iow_sync  <= {iow_sync[SYNC_STAGES-2:0], isa_iow_n};
    dack_sync <= {dack_sync[SYNC_STAGES-2:0], isa_dack_n};
    aen_sync  <= {aen_sync[SYNC_STAGES-2:0], isa_aen};
    rst_sync  <= {rst_sync[SYNC_STAGES-2:0], isa_reset};
    addr_sync[0] <= isa_address;
    data_sync[0] <= isa_data_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      addr_sync[i] <= addr_sync[i-1];
      data_sync[i] <= data_sync[i-1];
    end
  end

  // Synced views and decoded edges.
  always_comb begin
    ior_s       = ior_sync[SYNC_STAGES-1];
    iow_s       = iow_sync[SYNC_STAGES-1];
    dack_s      = dack_sync[SYNC_STAGES-1];
    aen_s       = aen_sync[SYNC_STAGES-1];
    isa_reset_s = rst_sync[SYNC_STAGES-1];
    addr_s      = addr_sync[SYNC_STAGES-1];
    data_s      = data_sync[SYNC_STAGES-1];
    ior_fall    = ior_q && !ior_s;
    iow_fall    = iow_q && !iow_s;
    ior_rise    = !ior_q && ior_s;
    iow_rise    = !iow_q && iow_s;
    dack_fall   = dack_q && !dack_s;
    hit         = !aen_s && (addr_s[15:4] == BASE_ADDR[15:4]);
    both_low    = !ior_s && !iow_s;
  end

  // Main bus FSM with registered local-bus and ISA outputs.
  always_ff @(posedge clk) begin
    // Edge registers follow the bus even in reset, so a strobe held across reset
    // release is not mistaken for a fresh edge.
    ior_q  <= ior_s;
    iow_q  <= iow_s;
    dack_q <= dack_s;
    if (reset || isa_reset_s) begin
      state        <= StIdle;
      isa_data_out <= 8'h00;
      isa_data_oe  <= 1'b0;
      isa_drq      <= 1'b0;
      wr_valid     <= 1'b0;
      wr_addr      <= 4'h0;
      wr_data      <= 8'h00;
      rd_req       <= 1'b0;
      rd_addr      <= 4'h0;
      dma_valid    <= 1'b0;
      dma_data     <= 8'h00;
      data_hold    <= 8'h00;
      rd_timer     <= '0;
      drq_block    <= 1'b0;
    end else begin
      wr_valid  <= 1'b0;
      rd_req    <= 1'b0;
      dma_valid <= 1'b0;
      drq_block <= 1'b0;
      if (dack_fall) begin
        isa_drq <= 1'b0;
      end
      unique case (state)
        StIdle: begin
          isa_data_oe <= 1'b0;
          if (!dack_fall && dma_ready && dack_s && !drq_block) begin
            isa_drq <= 1'b1;
          end
          if (!both_low) begin
            if (iow_fall && !dack_s && aen_s) begin
              // DMA write: address decode does not apply.
              state     <= StDmaWr;
              data_hold <= data_s;
              isa_drq   <= 1'b0;
            end else if (iow_fall && hit) begin
              state     <= StIoWr;
              wr_addr   <= addr_s[3:0];
              data_hold <= data_s;
            end else if (ior_fall && hit && dack_s) begin
              state    <= StRdWait;
              rd_req   <= 1'b1;
              rd_addr  <= addr_s[3:0];
              rd_timer <= '0;
            end
          end
        end
        StIoWr: begin
          if (iow_rise) begin
            state    <= StIdle;
            wr_valid <= 1'b1;
            wr_data  <= data_hold;
          end else begin
            data_hold <= data_s;
          end
        end
        StRdWait: begin
          if (ior_rise) begin
            // Host gave up before data was ready; nothing is driven.
            state <= StIdle;
          end else if (rd_valid) begin
            state        <= StRdDrive;
            isa_data_out <= rd_data;
            isa_data_oe  <= 1'b1;
          end else if (rd_timer == TW'(RD_TIMEOUT - 1)) begin
            state        <= StRdDrive;
            isa_data_out <= 8'hFF;
            isa_data_oe  <= 1'b1;
          end else begin
            rd_timer <= rd_timer + TW'(1);
          end
        end
        StRdDrive: begin
          if (ior_rise) begin
            state        <= StIdle;
            isa_data_oe  <= 1'b0;
            isa_data_out <= 8'h00;
          end
        end
        StDmaWr: begin
          if (iow_rise) begin
            state     <= StIdle;
            dma_valid <= 1'b1;
            dma_data  <= data_hold;
            drq_block <= 1'b1;
          end else begin
            data_hold <= data_s;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // IRQ latch (set wins over clear) and its registered output.
  always_ff @(posedge clk) begin
    if (reset || isa_reset_s) begin
      irq_latch <= 1'b0;
      isa_irq   <= 1'b0;
    end else begin
      if (irq_set) begin
        irq_latch <= 1'b1;
      end else if (irq_clr) begin
        irq_latch <= 1'b0;
      end
      isa_irq <= irq_latch;
    end
  end

endmodule
